// File: rtl/uart_apb_bridge.sv
// Debug-host APB initiator: command bytes in, one APB access per command, status/data bytes out.
// Define UART_APB_BRIDGE_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module uart_apb_bridge #(
   parameter logic [7:0] CMD_WRITE      = 8'h01,
   parameter logic [7:0] CMD_READ       = 8'h02,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n_sync,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        apbm_psel,
   output logic        apbm_penable,
   output logic        apbm_pwrite,
   output logic [15:0] apbm_paddr,
   output logic [31:0] apbm_pwdata,
   input  logic [31:0] apbm_prdata,
   input  logic        apbm_pready,
   input  logic        apbm_pslverr,
   output logic        busy
);
   typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RESP} state_t;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_SLVERR  = 8'h01;
   localparam logic [7:0] ST_TIMEOUT = 8'h02;
   localparam logic [7:0] ST_BADOP   = 8'hFF;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  last_q, last_d;   // index of the final response byte
   logic        pwrite_q, pwrite_d;
   logic [15:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [31:0] prdata_q, prdata_d;
   logic [7:0]  status_q, status_d;
   logic        rx_fire, tx_fire, timeout_hit;

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_q, wait_d;

   always_comb begin
      wait_d = wait_q;
      if (state_q != S_ACCESS)
         wait_d = '0;
      else if (!apbm_pready)
         wait_d = wait_q + CW'(1);
   end

   // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES; pready wins that cycle.
   assign timeout_hit = (state_q == S_ACCESS) && !apbm_pready &&
                        (wait_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) wait_q <= '0;
      else             wait_q <= wait_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
`endif

   assign rx_fire = rx_valid && rx_ready;
   assign tx_fire = tx_valid && tx_ready;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      prdata_d = prdata_q;
      status_d = status_q;
      case (state_q)
         S_CMD: if (rx_fire) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
               pwrite_d = (rx_data == CMD_WRITE);
               last_d   = (rx_data == CMD_WRITE) ? 3'd0 : 3'd4;
               state_d  = S_ADDR;
            end else begin
               status_d = ST_BADOP;
               last_d   = 3'd0;
               state_d  = S_RESP;
            end
         end
         S_ADDR: if (rx_fire) begin
            if (idx_q[0]) paddr_d[15:8] = rx_data;
            else          paddr_d[7:0]  = rx_data;
            idx_d = idx_q + 3'd1;
            if (idx_q[0]) state_d = pwrite_q ? S_WDATA : S_SETUP;
         end
         S_WDATA: if (rx_fire) begin
            pwdata_d[{idx_q[1:0], 3'b000} +: 8] = rx_data;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd3) state_d = S_SETUP;
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (apbm_pready) begin
               status_d = apbm_pslverr ? ST_SLVERR : ST_OK;
               if (!pwrite_q) prdata_d = apbm_prdata;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               status_d = ST_TIMEOUT;
               prdata_d = '0;
               state_d  = S_RESP;
            end
         end
         S_RESP: if (tx_fire) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == last_q) state_d = S_CMD;
         end
         default: state_d = S_CMD;
      endcase
      if (state_d != state_q) idx_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state_q  <= S_CMD;
         idx_q    <= '0;
         last_q   <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         prdata_q <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         prdata_q <= prdata_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      case (idx_q)
         3'd1:    tx_data = prdata_q[7:0];
         3'd2:    tx_data = prdata_q[15:8];
         3'd3:    tx_data = prdata_q[23:16];
         3'd4:    tx_data = prdata_q[31:24];
         default: tx_data = status_q;
      endcase
   end

   assign rx_ready     = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
   assign tx_valid     = (state_q == S_RESP);
   assign busy         = (state_q != S_CMD);
   assign apbm_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign apbm_penable = (state_q == S_ACCESS);
   assign apbm_pwrite  = pwrite_q;
   assign apbm_paddr   = paddr_q;
   assign apbm_pwdata  = pwdata_q;
endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- Debug-host APB initiator: takes command bytes from a byte stream (UART RX side), issues one APB read or write per command, and returns status/data bytes on a byte stream (UART TX side).
- Sits between a UART byte engine and the peripheral APB bus, so a host can drive uart_mini-class APB slaves with no CPU present.
- One transaction outstanding at a time; no internal FIFOs.

Parameters:
- CMD_WRITE, 8'h01, opcode byte for APB write.
- CMD_READ, 8'h02, opcode byte for APB read.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles before abort; used only with the optional feature; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n_sync  in  1  reset, asynchronous, active-low.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts tx_data this cycle.
- apbm_psel  out  1  APB select.
- apbm_penable  out  1  APB enable.
- apbm_pwrite  out  1  APB write.
- apbm_paddr  out  16  APB address.
- apbm_pwdata  out  32  APB write data.
- apbm_prdata  in  32  APB read data.
- apbm_pready  in  1  APB ready.
- apbm_pslverr  in  1  APB slave error.
- busy  out  1  high in every state except CMD.

Behaviour:
- Reset values: all outputs 0, except tx_data = 8'h00 and rx_ready = 1 (state CMD). All internal registers 0.
- Byte transfer: a byte moves when valid && ready are both high on a clock edge. tx_data is held stable while tx_valid=1 && !tx_ready.
- Frame format, little-endian: opcode, addr[7:0], addr[15:8], then for a write only wdata[7:0]..wdata[31:24].
- Write response: 1 status byte. Read response: status byte, then prdata[7:0]..[31:24]. The 4 data bytes are always sent, even on error, with the registered prdata value.
- Status codes: 8'h00 OK; 8'h01 pslverr; 8'h02 timeout; 8'hFF unknown opcode.
- FSM states and transitions:
  - CMD: rx_ready=1. On accept: if opcode is CMD_WRITE or CMD_READ, latch pwrite and go to ADDR; any other opcode latches status 8'hFF and goes to RESP with a 1-byte response.
  - ADDR: rx_ready=1. Accepts 2 bytes using a byte index. Goes to WDATA if write, else to SETUP.
  - WDATA: rx_ready=1. Accepts 4 bytes into pwdata, then goes to SETUP.
  - SETUP: exactly 1 cycle; psel=1, penable=0; paddr, pwrite and pwdata driven from registers.
  - ACCESS: psel=1, penable=1. On pready=1: capture prdata (reads) and pslverr into status; next cycle psel=0, penable=0, go to RESP.
  - RESP: tx_valid=1. Index steps 0..N-1 on each accepted byte; after the last byte, go to CMD.
- rx_ready=0 in SETUP, ACCESS and RESP. Input bytes are back-pressured, never dropped.
- Latency:
  - Last command byte accepted at edge N -> psel=1 in cycle N+1, penable=1 in cycle N+2.
  - With pready=1 in cycle N+2, tx_valid=1 in cycle N+3.
- APB outputs (paddr, pwrite, pwdata) are stable from SETUP through the end of ACCESS. pwdata and paddr keep their last values when idle.
- Byte index wraps to 0 on every state change.
- Asynchronous reset mid-frame or mid-APB: immediate return to CMD and reset values. A partial frame is discarded; the APB access is abandoned.
- No inter-byte timeout: a stalled frame waits indefinitely.

Optional Feature:
- Macro: UART_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An ACCESS wait counter clears on entering ACCESS and increments each cycle pready=0.
  - When the count reaches TIMEOUT_CYCLES without pready, the access is aborted: psel and penable drop the next cycle, status becomes 8'h02, and the state goes to RESP. Read data is 32'h0.
  - pready arriving in the same cycle the count reaches TIMEOUT_CYCLES counts as success.
- Undefined: no counter; ACCESS waits indefinitely; status 8'h02 is never produced.

Test Plan:
- Write: rx 01 34 12 EF BE AD DE, pready=1 -> one APB write, paddr=16'h1234, pwdata=32'hDEADBEEF, psel for 2 cycles; tx 00.
- Read: rx 02 08 00, slave returns 32'hCAFE0042 with 3 wait states -> penable held 4 cycles; tx 00 42 00 FE CA.
- Error/back-pressure: pslverr=1 on a read, tx_ready toggled 1-0-1 -> tx 01 + 4 data bytes, each byte stable while stalled; rx_ready=0 throughout.
- Bad opcode: rx 7F -> no psel activity; tx FF; the next rx byte is treated as an opcode.
- Reset mid-frame: rx 01 34, then assert rst_n_sync=0 -> all outputs at reset values; a following rx 02 00 00 is decoded as a fresh read.
- Timeout (macro defined, TIMEOUT_CYCLES=4): pready held 0 -> abort after 4 wait cycles; tx 02 00 00 00 00.
